// File: rtl/insn_loader_pkg.sv
// Shared constants and state encoding for the boot-stream instruction loader.
package insn_loader_pkg;

  localparam int MEM_DEPTH = 1024;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);
  localparam int HDR_W     = 16;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERR
  } state_t;

  function automatic logic is_loading(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
  endfunction

endpackage

// File: rtl/insn_loader_word_assembler.sv
// Collects little-endian byte lanes into one word; word_valid pulses the cycle
// after the final lane byte arrives, with word_out holding the completed word.
module word_assembler
  import insn_loader_pkg::*;
#(
  parameter int LANES = NUM_LANES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANE_W-1:0]       byte_in,
  input  logic                    byte_valid,
  output logic                    last_lane,
  output logic                    word_valid,
  output logic [LANES*LANE_W-1:0] word_out
);

  localparam int LW = $clog2(LANES);

  logic [LW-1:0]                   lane;
  logic [LANES-2:0][LANE_W-1:0]    lanes;

  assign last_lane = (lane == LW'(LANES - 1));

  // The top lane is never stored: it is taken straight from byte_in.
  for (genvar i = 0; i < LANES - 1; i++) begin : g_lane
    logic [LANE_W-1:0] q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  q <= '0;
      else if (byte_valid && lane == LW'(i))    q <= byte_in;
    end
    assign lanes[i] = q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= '0;
      word_valid <= 1'b0;
      word_out   <= '0;
    end else begin
      word_valid <= byte_valid && last_lane;
      if (byte_valid) begin
        lane <= last_lane ? '0 : lane + 1'b1;
        if (last_lane) word_out <= {byte_in, lanes};
      end
    end
  end

endmodule

// File: rtl/insn_loader.sv
// Boot loader: parses a 16-bit word count then streams that many 32-bit words
// into instruction memory, releasing the core once the last word is written.
module insn_loader #(
  parameter int MEM_DEPTH = insn_loader_pkg::MEM_DEPTH,
  parameter int ADDR_W    = insn_loader_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  import insn_loader_pkg::*;

  state_t            state, state_nx;
  logic [7:0]        len_lo;
  logic [ADDR_W:0]   n_words;
  logic [HDR_W-1:0]  hdr_n;
  logic              xfer, lane_byte, last_lane, last_word, final_byte;

  assign xfer       = in_valid && in_ready;
  assign hdr_n      = {in_data, len_lo};
  assign lane_byte  = xfer && (state == DATA);
  assign last_word  = (words_loaded == n_words - (ADDR_W+1)'(1));
  // Stop accepting once the final byte is in, so nothing leaks into the lanes
  // during the write cycle that precedes DONE.
  assign final_byte = lane_byte && last_lane && last_word;
  assign mem_addr   = words_loaded[ADDR_W-1:0];

  word_assembler #(.LANES(NUM_LANES)) u_asm (
    .clk       (clk),
    .rst       (reset),
    .byte_in   (in_data),
    .byte_valid(lane_byte),
    .last_lane (last_lane),
    .word_valid(mem_we),
    .word_out  (mem_wdata)
  );

  always_comb begin
    state_nx = state;
    case (state)
      LEN_LO: if (xfer) state_nx = LEN_HI;
      LEN_HI: if (xfer) begin
        if (int'(hdr_n) > MEM_DEPTH) state_nx = ERR;
        else if (hdr_n == '0)        state_nx = DONE;
        else                         state_nx = DATA;
      end
      DATA:   if (mem_we && last_word) state_nx = DONE;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LEN_LO;
      len_lo       <= '0;
      n_words      <= '0;
      words_loaded <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      core_run     <= 1'b0;
      error        <= 1'b0;
    end else begin
      state    <= state_nx;
      in_ready <= is_loading(state_nx) && !final_byte;
      busy     <= is_loading(state_nx);
      core_run <= (state_nx == DONE);
      error    <= (state_nx == ERR);
      if (xfer && state == LEN_LO) len_lo <= in_data;
      if (xfer && state == LEN_HI) n_words <= (ADDR_W+1)'(hdr_n);
      if (mem_we) words_loaded <= words_loaded + 1'b1;
    end
  end

endmodule

// File: doc/insn_loader.md
INSN_LOADER -- requirements
Module: insn_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, instruction-memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 10, word-address width; SHALL equal clog2(MEM_DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  8  boot-stream byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts a byte; a byte transfers when in_valid and in_ready are both high at a clock edge.
REQ-008 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 mem_addr  output  ADDR_W  word address for the write.
REQ-010 mem_wdata  output  32  instruction word.
REQ-011 core_run  output  1  releases the core; low while loading.
REQ-012 busy  output  1  load in progress.
REQ-013 error  output  1  header rejected; sticky until reset.
REQ-014 words_loaded  output  ADDR_W+1  count of words written.

Function
REQ-015 Stream format: 16-bit word count N, little-endian over 2 bytes, then N words of 4 bytes each, little-endian (first byte is bits 7:0).
REQ-016 FSM states: LEN_LO, LEN_HI, DATA, DONE, ERR; state after reset is LEN_LO.
REQ-017 in_ready SHALL be 1 in LEN_LO, LEN_HI and DATA, and 0 in DONE and ERR; it is registered and never depends combinationally on in_valid.
REQ-018 LEN_LO goes to LEN_HI on a byte transfer.
REQ-019 LEN_HI on a byte transfer goes to:
- ERR if N > MEM_DEPTH.
- DONE if N == 0.
- DATA otherwise.
REQ-020 In DATA, a 2-bit lane counter tracks bytes; on the 4th transfer the assembled word is registered.
REQ-021 mem_we SHALL pulse for exactly one cycle, the cycle after the 4th byte transfer; mem_addr = words_loaded before increment; mem_wdata = assembled word.
REQ-022 words_loaded increments in the same cycle that mem_we is high.
REQ-023 When the word with index N-1 is written, the FSM enters DONE; core_run rises the cycle after that final mem_we pulse.
REQ-024 For N == 0, core_run rises the cycle after the LEN_HI transfer.
REQ-025 Back-to-back bytes, one per cycle, SHALL be accepted without stalls; gaps in in_valid simply pause assembly.
REQ-026 mem_addr SHALL never exceed MEM_DEPTH-1; no wrap-around occurs because N ≤ MEM_DEPTH is enforced.
REQ-027 busy = 1 in LEN_LO, LEN_HI and DATA; busy = 0 in DONE and ERR.
REQ-028 error = 1 only in ERR; core_run stays 0 in ERR.
REQ-029 Bytes offered in DONE or ERR are not consumed.

Reset
REQ-030 Values while reset is high:
- in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
- core_run=0, busy=0, error=0, words_loaded=0.
- lane counter=0.
REQ-031 The cycle after reset deasserts, state is LEN_LO with in_ready=1 and busy=1.
REQ-032 Reset mid-load discards the partial word and restarts from the header; memory contents are not cleared.

Structure
REQ-033 Shared package holds MEM_DEPTH, ADDR_W, the state enumeration and the header width (16).
REQ-034 One sub-module, word_assembler, holds the byte lanes and lane counter and emits a word_valid pulse.

Verification
REQ-035 Stream 03 00 + words 0x03208093, 0x00110113, 0x4020D1B3, one byte per cycle -> three mem_we pulses at addr 0,1,2 with exact words; core_run rises 1 cycle after the third pulse; words_loaded=3.
REQ-036 Header 00 00 -> no mem_we; core_run=1 the cycle after the 2nd byte; in_ready=0 afterwards.
REQ-037 Header 01 04 (N=1025) -> error=1, in_ready=0, core_run=0; later bytes not accepted.
REQ-038 N=2 with in_valid toggled randomly -> identical writes and data as the gap-free case.
REQ-039 Reset asserted after 6 bytes of an N=2 load, then a fresh N=1 stream -> single write at addr 0 with the new word; words_loaded=1.
REQ-040 N=1024 full load -> last write at addr 1023; core_run=1; words_loaded=1024.
